// File: rtl/cpld_nrom_pkg.sv
// cpld_nrom_pkg: shared types and CPC bus constants for the ROM board CPLD.
package cpld_nrom_pkg;

    // Configuration port unlock/programming sequencer states
    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        KEY_1  = 2'd1,
        OPEN   = 2'd2,
        DATA   = 2'd3
    } cfg_state_t;

    // Writing this byte in OPEN relocks the mapping table
    localparam logic [7:0] LOCK_CMD       = 8'hFF;

    // CPC upper-ROM select port high byte (&DFxx)
    localparam logic [7:0] ROMSEL_PORT_HI = 8'hDF;

    // Bit positions of A13 and A14 within adr_hi (A15..A8)
    localparam int A13_BIT = 5;
    localparam int A14_BIT = 6;

endpackage

// File: rtl/cpld_nrom_iowr.sv
// iowr_edge_det: synchronises the Z80 IO-write term into clk and emits a
// single-cycle strobe on its rising edge, however long the write is held.
module iowr_edge_det (
    input  logic clk,
    input  logic reset_b,
    input  logic ioreq_b,
    input  logic wr_b,
    output logic wstb
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Two-flop synchroniser followed by a delay flop for edge detection
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= ~ioreq_b & ~wr_b;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign wstb = sync_p1 & ~sync_p2;

endmodule

// File: rtl/cpld_nrom.sv
// cpld_nrom: CPC expansion ROM board decoder. Maps NUM_SKT 16K banks (two per
// 32K device) onto upper ROM numbers through a key-unlocked run-time table.
// Build option ROMSEL_FULL_DECODE_EN: ROM select latch loads only on a fully
// decoded &DF port; otherwise the legacy A13-low partial decode is used.
module cpld_nrom
    import cpld_nrom_pkg::*;
#(
    parameter int         NUM_SKT  = 6,
    parameter logic [7:0] BASE_ROM = 8'h01,
    parameter logic [7:0] CFG_PORT = 8'hFE,
    parameter logic [7:0] KEY0     = 8'hA5,
    parameter logic [7:0] KEY1     = 8'h5A
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic [7:0]             adr_hi,
    input  logic                   ioreq_b,
    input  logic                   wr_b,
    input  logic                   romen_b,
    input  logic [7:0]             data,
    input  logic [NUM_SKT-1:0]     dip,
    input  logic                   lowrom_en,
    output logic [NUM_SKT/2-1:0]   romcs_b,
    output logic                   roma14,
    output logic                   romoe_b,
    output logic                   romdis
);

    localparam logic [4:0] SKT_CNT = 5'(NUM_SKT);

    logic               wstb;
    logic               romsel_hit;
    logic               cfg_wr;
    logic [7:0]         romsel_q;
    cfg_state_t         cfg_state;
    logic [3:0]         idx_q;
    logic [7:0]         map_q [NUM_SKT];
    logic [NUM_SKT-1:0] sel;

    iowr_edge_det u_iowr (
        .clk     (clk),
        .reset_b (reset_b),
        .ioreq_b (ioreq_b),
        .wr_b    (wr_b),
        .wstb    (wstb)
    );

`ifdef ROMSEL_FULL_DECODE_EN
    assign romsel_hit = (adr_hi == ROMSEL_PORT_HI);
`else
    assign romsel_hit = ~adr_hi[A13_BIT];
`endif

    assign cfg_wr = wstb & (adr_hi == CFG_PORT);

    // ROM select latch, loaded once per IO write to the select port
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            romsel_q <= 8'h00;
        else if (wstb && romsel_hit)
            romsel_q <= data;
    end

    // Unlock sequencer and mapping-table writes; reset drops any partial entry
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cfg_state <= LOCKED;
            idx_q     <= 4'd0;
            for (int i = 0; i < NUM_SKT; i++)
                map_q[i] <= 8'(BASE_ROM + i);
        end else if (cfg_wr) begin
            case (cfg_state)
                LOCKED: begin
                    if (data == KEY0)
                        cfg_state <= KEY_1;
                end
                KEY_1: begin
                    cfg_state <= (data == KEY1) ? OPEN : LOCKED;
                end
                OPEN: begin
                    if (data == LOCK_CMD) begin
                        cfg_state <= LOCKED;
                    end else if ({1'b0, data[3:0]} < SKT_CNT) begin
                        idx_q     <= data[3:0];
                        cfg_state <= DATA;
                    end
                end
                DATA: begin
                    for (int i = 0; i < NUM_SKT; i++)
                        if (idx_q == 4'(i))
                            map_q[i] <= data;
                    cfg_state <= OPEN;
                end
                default: cfg_state <= LOCKED;
            endcase
        end
    end

    // Bank decode: lower ROM replacement in A14-low, priority table match above
    always_comb begin
        sel = '0;
        if (!adr_hi[A14_BIT]) begin
            sel[0] = dip[0] & lowrom_en;
        end else begin
            for (int i = NUM_SKT - 1; i >= 0; i--) begin
                if (dip[i] && (map_q[i] == romsel_q) && !(i == 0 && lowrom_en)) begin
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end
    end

    // Device chip selects and half select from the one-hot bank select
    always_comb begin
        roma14 = 1'b0;
        for (int k = 0; k < NUM_SKT / 2; k++) begin
            romcs_b[k] = ~(sel[2*k] | sel[2*k+1]);
            roma14     = roma14 | sel[2*k+1];
        end
    end

    assign romdis  = |sel;
    assign romoe_b = romen_b;

endmodule
